// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the single-master peripheral bus decoder.
// Latches the winner's command, replays it with one-cycle strobes, returns data and an ack.
module bus_arbiter #(
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_request,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_write_data,
    output logic [31:0] m0_read_data,
    output logic        m0_ack,
    input  logic        m1_request,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_write_data,
    output logic [31:0] m1_read_data,
    output logic        m1_ack,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    localparam logic [3:0] LATENCY      = 4'(READ_LATENCY);
    localparam bit         ZERO_LATENCY = (READ_LATENCY == 0);

    state_t      state_q;
    logic        owner_q;
    logic        last_grant_q;
    logic        lat_read_q;
    logic        lat_write_q;
    logic [3:0]  count_q;
    logic [31:0] m0_read_data_q;
    logic [31:0] m1_read_data_q;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic        bus_read_q;
    logic        bus_write_q;
    logic [31:0] bus_address_q;
    logic [31:0] bus_write_data_q;
    logic [1:0]  grant_q;
    logic        busy_q;

    logic        start_d;
    logic        pick_m1_d;
    logic        sel_read_d;
    logic        sel_write_d;
    logic [31:0] sel_address_d;
    logic [31:0] sel_write_data_d;

    // Returns 1 when master 1 should win this IDLE cycle; ties go to the master not served last.
    function automatic logic pick_m1(input logic req0, input logic req1, input logic last_m1);
        logic win;
        if (req0 && req1) begin
            win = FIXED_PRIORITY ? 1'b0 : ~last_m1;
        end else begin
            win = req1;
        end
        return win;
    endfunction

    // Arbitration decision and the winning master's command.
    always_comb begin
        start_d          = m0_request | m1_request;
        pick_m1_d        = pick_m1(m0_request, m1_request, last_grant_q);
        sel_read_d       = pick_m1_d ? m1_read       : m0_read;
        sel_write_d      = pick_m1_d ? m1_write      : m0_write;
        sel_address_d    = pick_m1_d ? m1_address    : m0_address;
        sel_write_data_d = pick_m1_d ? m1_write_data : m0_write_data;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            owner_q          <= 1'b0;
            last_grant_q     <= 1'b1;
            lat_read_q       <= 1'b0;
            lat_write_q      <= 1'b0;
            count_q          <= 4'd0;
            m0_read_data_q   <= 32'd0;
            m1_read_data_q   <= 32'd0;
            m0_ack_q         <= 1'b0;
            m1_ack_q         <= 1'b0;
            bus_read_q       <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_address_q    <= 32'd0;
            bus_write_data_q <= 32'd0;
            grant_q          <= 2'b00;
            busy_q           <= 1'b0;
        end else begin
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        // The bus address/data registers double as the command latch.
                        owner_q          <= pick_m1_d;
                        lat_read_q       <= sel_read_d;
                        lat_write_q      <= sel_write_d;
                        bus_address_q    <= sel_address_d;
                        bus_write_data_q <= sel_write_data_d;
                        bus_write_q      <= sel_write_d;
                        bus_read_q       <= sel_read_d & ~sel_write_d;
                        grant_q          <= pick_m1_d ? 2'b10 : 2'b01;
                        busy_q           <= 1'b1;
                        state_q          <= ST_ACCESS;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (lat_write_q || !lat_read_q) begin
                        m0_ack_q <= ~owner_q;
                        m1_ack_q <= owner_q;
                        state_q  <= ST_RESPOND;
                    end else if (ZERO_LATENCY) begin
                        if (owner_q) begin
                            m1_read_data_q <= bus_read_data;
                        end else begin
                            m0_read_data_q <= bus_read_data;
                        end
                        m0_ack_q <= ~owner_q;
                        m1_ack_q <= owner_q;
                        state_q  <= ST_RESPOND;
                    end else begin
                        count_q <= LATENCY;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    count_q <= count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        if (owner_q) begin
                            m1_read_data_q <= bus_read_data;
                        end else begin
                            m0_read_data_q <= bus_read_data;
                        end
                        m0_ack_q <= ~owner_q;
                        m1_ack_q <= owner_q;
                        state_q  <= ST_RESPOND;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_RESPOND: begin
                    last_grant_q     <= owner_q;
                    grant_q          <= 2'b00;
                    busy_q           <= 1'b0;
                    bus_address_q    <= 32'd0;
                    bus_write_data_q <= 32'd0;
                    state_q          <= ST_IDLE;
                end
                default: begin
                    grant_q          <= 2'b00;
                    busy_q           <= 1'b0;
                    bus_address_q    <= 32'd0;
                    bus_write_data_q <= 32'd0;
                    state_q          <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_read_data   = m0_read_data_q;
    assign m1_read_data   = m1_read_data_q;
    assign m0_ack         = m0_ack_q;
    assign m1_ack         = m1_ack_q;
    assign bus_read       = bus_read_q;
    assign bus_write      = bus_write_q;
    assign bus_address    = bus_address_q;
    assign bus_write_data = bus_write_data_q;
    assign grant          = grant_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three builds (latency 1 round-robin, latency 0 fixed, latency 3
// round-robin) driven by reactive masters and checked against a transaction-timing model.
module tb_bus_arbiter;

    localparam logic [2:0][3:0] LATS = {4'd3, 4'd0, 4'd1};
    localparam logic [2:0]      FPS  = 3'b010;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [2:0][1:0]        req, rdc, wrc;
    logic [2:0][1:0][31:0]  adr, wdt;
    logic [2:0][31:0]       brd;
    wire  [2:0][1:0]        ack_w;
    wire  [2:0][1:0][31:0]  rdata_w;
    wire  [2:0]             bus_rd_w, bus_wr_w, busy_w;
    wire  [2:0][31:0]       bus_addr_w, bus_wdo_w;
    wire  [2:0][1:0]        grant_w;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_arbiter #(.READ_LATENCY(32'(LATS[g])), .FIXED_PRIORITY(FPS[g])) u_dut (
            .clk(clk), .reset(reset),
            .m0_request(req[g][0]), .m0_read(rdc[g][0]), .m0_write(wrc[g][0]),
            .m0_address(adr[g][0]), .m0_write_data(wdt[g][0]),
            .m0_read_data(rdata_w[g][0]), .m0_ack(ack_w[g][0]),
            .m1_request(req[g][1]), .m1_read(rdc[g][1]), .m1_write(wrc[g][1]),
            .m1_address(adr[g][1]), .m1_write_data(wdt[g][1]),
            .m1_read_data(rdata_w[g][1]), .m1_ack(ack_w[g][1]),
            .bus_read(bus_rd_w[g]), .bus_write(bus_wr_w[g]),
            .bus_address(bus_addr_w[g]), .bus_write_data(bus_wdo_w[g]),
            .bus_read_data(brd[g]),
            .grant(grant_w[g]), .busy(busy_w[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;
    int mode  = 0;   // 0 directed, 1 continuous reads, 2 random

    // Reference model: one outstanding transaction per build, described by its start cycle.
    bit          act   [3];
    int          c0    [3];
    int          own   [3];
    int          kind  [3];   // 0 no-op, 1 read, 2 write
    int          dur   [3];
    int          lastg [3];
    logic [31:0] laddr [3];
    logic [31:0] lwd   [3];
    logic [31:0] smp   [3];
    logic [31:0] exp_rd[3][2];

    logic [1:0]  ack_seen[3];
    int          fa[3], nrs[3], nws[3], gcnt[3];
    logic [1:0]  pg[3];
    logic [1:0]  gseq[3][8];

    function automatic int lat_of(input int i);
        return int'(LATS[i]);
    endfunction

    task automatic chk(input int i, input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL i%0d c%0d %s observed=%0h expected=%0h", i, n, nm, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0; lastg[i] = 1; c0[i] = 0; dur[i] = 0; own[i] = 0; kind[i] = 0;
            exp_rd[i][0] = 32'd0; exp_rd[i][1] = 32'd0; ack_seen[i] = 2'b00; pg[i] = 2'b00;
            for (int m = 0; m < 2; m++) begin
                req[i][m] = 1'b0; rdc[i][m] = 1'b0; wrc[i][m] = 1'b0;
                adr[i][m] = 32'd0; wdt[i][m] = 32'd0;
            end
            brd[i] = 32'd0;
        end
    endtask

    task automatic new_cmd(input int i, input int m, input bit rd_only);
        req[i][m] = 1'b1;
        if (rd_only) begin
            rdc[i][m] = 1'b1; wrc[i][m] = 1'b0;
        end else begin
            {rdc[i][m], wrc[i][m]} = 2'($urandom_range(0, 3));
        end
        adr[i][m] = $urandom();
        wdt[i][m] = $urandom();
    endtask

    task automatic drive_master(input int i, input int m);
        if (ack_seen[i][m]) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) new_cmd(i, m, mode == 1);
            else req[i][m] = 1'b0;
        end else if (!req[i][m]) begin
            if (mode == 2 && $urandom_range(0, 3) == 0) new_cmd(i, m, 1'b0);
        end else if (mode == 2 && act[i] && own[i] == m && $urandom_range(0, 1) == 1) begin
            adr[i][m] = $urandom();
            wdt[i][m] = $urandom();
            {rdc[i][m], wrc[i][m]} = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic model_step(input int i);
        int o;
        if (act[i] && n > c0[i] + dur[i]) act[i] = 1'b0;
        if (!act[i] && (req[i][0] || req[i][1])) begin
            if (req[i][0] && req[i][1]) o = FPS[i] ? 0 : 1 - lastg[i];
            else o = req[i][1] ? 1 : 0;
            act[i] = 1'b1; c0[i] = n; own[i] = o; lastg[i] = o;
            kind[i] = wrc[i][o] ? 2 : (rdc[i][o] ? 1 : 0);
            laddr[i] = adr[i][o]; lwd[i] = wdt[i][o];
            dur[i] = (kind[i] == 1) ? 2 + lat_of(i) : 2;
        end
        if (act[i] && kind[i] == 1 && n == c0[i] + 1 + lat_of(i)) smp[i] = brd[i];
        if (act[i] && kind[i] == 1 && n == c0[i] + dur[i]) exp_rd[i][own[i]] = smp[i];
    endtask

    task automatic check_inst(input int i);
        bit in_tx;
        in_tx = act[i] && (n > c0[i]) && (n <= c0[i] + dur[i]);
        chk(i, "grant", 32'(grant_w[i]), !in_tx ? 32'd0 : (own[i] == 1 ? 32'd2 : 32'd1));
        chk(i, "busy", 32'(busy_w[i]), 32'(in_tx));
        chk(i, "bus_read", 32'(bus_rd_w[i]), 32'(in_tx && n == c0[i] + 1 && kind[i] == 1));
        chk(i, "bus_write", 32'(bus_wr_w[i]), 32'(in_tx && n == c0[i] + 1 && kind[i] == 2));
        chk(i, "m0_ack", 32'(ack_w[i][0]), 32'(in_tx && n == c0[i] + dur[i] && own[i] == 0));
        chk(i, "m1_ack", 32'(ack_w[i][1]), 32'(in_tx && n == c0[i] + dur[i] && own[i] == 1));
        chk(i, "m0_read_data", rdata_w[i][0], exp_rd[i][0]);
        chk(i, "m1_read_data", rdata_w[i][1], exp_rd[i][1]);
        if (!in_tx) begin
            chk(i, "bus_address_idle", bus_addr_w[i], 32'd0);
            chk(i, "bus_write_data_idle", bus_wdo_w[i], 32'd0);
        end else begin
            if (n < c0[i] + dur[i]) chk(i, "bus_address", bus_addr_w[i], laddr[i]);
            if (n == c0[i] + 1) chk(i, "bus_write_data", bus_wdo_w[i], lwd[i]);
        end
        ack_seen[i] = ack_w[i];
        if (fa[i] < 0 && ack_w[i] != 2'b00) fa[i] = n;
        nrs[i] += int'(bus_rd_w[i]);
        nws[i] += int'(bus_wr_w[i]);
        if (grant_w[i] != 2'b00 && pg[i] == 2'b00 && gcnt[i] < 8) begin
            gseq[i][gcnt[i]] = grant_w[i];
            gcnt[i]++;
        end
        pg[i] = grant_w[i];
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        #1;
    endtask

    task automatic eval();
        for (int i = 0; i < 3; i++) begin
            for (int m = 0; m < 2; m++) drive_master(i, m);
            if (mode != 0) brd[i] = $urandom();
            model_step(i);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_inst(i);
    endtask

    task automatic cycle();
        tick();
        eval();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk(i, "rst_grant", 32'(grant_w[i]), 32'd0);
            chk(i, "rst_busy", 32'(busy_w[i]), 32'd0);
            chk(i, "rst_strobes", 32'({bus_rd_w[i], bus_wr_w[i]}), 32'd0);
            chk(i, "rst_bus_address", bus_addr_w[i], 32'd0);
            chk(i, "rst_bus_write_data", bus_wdo_w[i], 32'd0);
            chk(i, "rst_ack", 32'(ack_w[i]), 32'd0);
            chk(i, "rst_m0_read_data", rdata_w[i][0], 32'd0);
            chk(i, "rst_m1_read_data", rdata_w[i][1], 32'd0);
        end
        model_init();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issue one identical transaction on every build and check its latency and strobes.
    task automatic dir_txn(input int m, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rv);
        int t0;
        for (int i = 0; i < 3; i++) begin
            brd[i] = rv; fa[i] = -1; nrs[i] = 0; nws[i] = 0;
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            req[i][m] = 1'b1; rdc[i][m] = r; wrc[i][m] = w; adr[i][m] = a; wdt[i][m] = d;
        end
        t0 = n;
        eval();
        repeat (8) cycle();
        for (int i = 0; i < 3; i++) begin
            chk(i, "ack_latency", 32'(fa[i] - t0), (r && !w) ? 32'(2 + lat_of(i)) : 32'd2);
            chk(i, "bus_read_pulses", 32'(nrs[i]), 32'(r && !w));
            chk(i, "bus_write_pulses", 32'(nws[i]), 32'(w));
        end
    endtask

    initial begin
        int t0;
        logic [1:0] exp_g;
        for (int i = 0; i < 3; i++) begin
            fa[i] = -1; nrs[i] = 0; nws[i] = 0; gcnt[i] = 0;
        end
        model_init();
        #1;
        do_reset();

        dir_txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            chk(i, "m0_rd_deadbeef", rdata_w[i][0], 32'hDEAD_BEEF);
            chk(i, "m1_rd_untouched", rdata_w[i][1], 32'd0);
        end

        dir_txn(1, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_00AA, 32'h5555_5555);
        for (int i = 0; i < 3; i++) begin
            chk(i, "m1_rd_after_write", rdata_w[i][1], 32'd0);
            chk(i, "m0_rd_kept", rdata_w[i][0], 32'hDEAD_BEEF);
        end

        mode = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            new_cmd(i, 0, 1'b1);
            new_cmd(i, 1, 1'b1);
            gcnt[i] = 0;
        end
        eval();
        repeat (30) cycle();
        mode = 0;
        repeat (16) cycle();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                exp_g = (FPS[i] || k % 2 == 0) ? 2'b01 : 2'b10;
                chk(i, $sformatf("grant_seq%0d", k), 32'(gseq[i][k]), 32'(exp_g));
            end
        end

        // Master changes its address right after being granted.
        tick();
        for (int i = 0; i < 3; i++) begin
            req[i][0] = 1'b1; rdc[i][0] = 1'b1; wrc[i][0] = 1'b0; adr[i][0] = 32'h10;
        end
        t0 = n;
        eval();
        tick();
        for (int i = 0; i < 3; i++) adr[i][0] = 32'h20;
        eval();
        cycle();
        chk(0, "addr_held_wait", bus_addr_w[0], 32'h10);
        chk(2, "addr_held_wait", bus_addr_w[2], 32'h10);
        repeat (6) cycle();

        // Reset while builds 0 and 2 sit in WAIT.
        tick();
        for (int i = 0; i < 3; i++) begin
            brd[i] = 32'hCAFE_F00D;
            req[i][0] = 1'b1; rdc[i][0] = 1'b1; wrc[i][0] = 1'b0; adr[i][0] = 32'h40;
        end
        eval();
        repeat (2) cycle();
        #2;
        do_reset();
        repeat (6) cycle();
        dir_txn(0, 1'b1, 1'b0, 32'h0000_0050, 32'd0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) chk(i, "fresh_after_reset", rdata_w[i][0], 32'h1234_5678);

        mode = 2;
        repeat (600) cycle();
        mode = 0;
        repeat (24) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter in front of the single-master peripheral BUS decoder.
- Master 0 is the core load/store port; master 1 is a secondary master such as a DMA or debug loader.
- Grants one master at a time, replays its latched command on the bus with one-cycle read/write strobes, waits the slave read latency, then returns data and a one-cycle ack.
- Supports round-robin or fixed-priority arbitration.

Parameters:
- READ_LATENCY, 1: cycles between the bus_read strobe cycle and the read-data sample cycle; legal range 0..15.
- FIXED_PRIORITY, 0: 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- m0_request  input  1  master 0 transaction request; held high until m0_ack
- m0_read  input  1  master 0 read command
- m0_write  input  1  master 0 write command
- m0_address  input  32  master 0 address
- m0_write_data  input  32  master 0 write data
- m0_read_data  output  32  master 0 returned read data (registered)
- m0_ack  output  1  master 0 completion pulse
- m1_request, m1_read, m1_write, m1_address, m1_write_data, m1_read_data, m1_ack: same as m0_*, for master 1
- bus_read  output  1  read strobe to the bus decoder
- bus_write  output  1  write strobe to the bus decoder
- bus_address  output  32  address to the bus decoder
- bus_write_data  output  32  write data to the bus decoder
- bus_read_data  input  32  read data from the bus decoder
- grant  output  2  one-hot owner: bit0 = m0, bit1 = m1; 00 when idle
- busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. On reset:
  - state = IDLE, grant = 00, busy = 0
  - all bus_* outputs = 0, both ack = 0, both read_data = 0
  - last_grant = m1, so m0 wins the first tie
  - Reset asserted mid-transaction aborts it immediately; no ack is issued.
- States:
  - IDLE:
    - If no request, stay.
    - If one request, grant it. If both, FIXED_PRIORITY=1 grants m0; otherwise grant the master that is not last_grant.
    - On grant, latch the master's address, write_data, read and write into internal registers, set grant, go to ACCESS.
    - Master inputs are ignored after the latch.
  - ACCESS (exactly 1 cycle):
    - bus_address and bus_write_data = latched values.
    - If latched write: bus_write = 1, go to RESPOND. Write wins if read and write are both set.
    - Else if latched read: bus_read = 1. With READ_LATENCY = 0, sample bus_read_data at the end of this cycle and go to RESPOND; otherwise load counter = READ_LATENCY, go to WAIT.
    - Else (neither read nor write): no strobe, go to RESPOND (no-op ack).
  - WAIT:
    - bus_read = 0, bus_write = 0; bus_address held at the latched value.
    - Counter decrements each cycle.
    - In the cycle where counter == 1, sample bus_read_data and go to RESPOND. WAIT therefore lasts READ_LATENCY cycles.
  - RESPOND (exactly 1 cycle):
    - The granted master's ack = 1.
    - For a read, its read_data = the sampled value. Writes and no-ops leave read_data unchanged.
    - last_grant = granted master; grant goes to 00 on exit; return to IDLE.
- Strobes: bus_read and bus_write are each high for exactly one cycle per transaction, so peripherals with pop-on-read FIFOs see a single access. In IDLE, bus_address and bus_write_data are driven to 0.
- Latency from the request sampled in IDLE (cycle 0) to ack:
  - write: ack in cycle 2
  - read: ack in cycle 2 + READ_LATENCY
- Master rules:
  - Master drops request in the cycle after it sees ack.
  - A request still high in the IDLE cycle after RESPOND is a new transaction.
  - The non-granted master's request stays pending; it is never dropped or acked early.
- Back-to-back: both masters requesting continuously alternate m0, m1, m0, … in round-robin mode. In fixed mode, m1 starves while m0 requests.
- read_data registers persist until that master's next read completes. The two masters' read_data are independent.

Test Plan:
- Reset, then m0 read at 0x00000010 with slave returning 0xDEADBEEF, READ_LATENCY=1 -> bus_read high one cycle at cycle 1; m0_ack in cycle 3; m0_read_data = 0xDEADBEEF; m1_* unchanged.
- m1 write of 0x000000AA to 0x00001000 -> bus_write high one cycle with the matching address/data; m1_ack in cycle 2; m1_read_data stays 0.
- m0 and m1 both request reads continuously, round-robin -> grant sequence 01, 10, 01, 10; each ack goes to the correct master with its own data. With FIXED_PRIORITY=1 -> m0 only while it keeps requesting.
- READ_LATENCY=0 and READ_LATENCY=3 builds -> read ack at cycle 2 and cycle 5 respectively; bus_read is asserted for exactly one cycle in each.
- m0 changes m0_address from 0x10 to 0x20 after grant -> bus_address stays 0x10 through WAIT.
- reset pulsed during WAIT -> all outputs return to 0 asynchronously, no ack is issued, and a fresh request after reset completes normally.
